// File: rtl/div_pkg.sv
// Shared types, constants and helpers for the fixed-point divider stream adapter.
`ifndef WIDTH
`define WIDTH 16
`endif
`ifndef Q_BITS
`define Q_BITS 12
`endif

package div_pkg;
  localparam int DIV_WIDTH  = `WIDTH;
  localparam int DIV_Q_BITS = `Q_BITS;
  localparam int DIV_TAG_W  = 6;

  // Saturated quotients returned for a zero divisor
  localparam logic [DIV_WIDTH-1:0] Q_MAX = {1'b0, {(DIV_WIDTH-1){1'b1}}};
  localparam logic [DIV_WIDTH-1:0] Q_MIN = {1'b1, {(DIV_WIDTH-1){1'b0}}};

  typedef struct packed {
    logic [DIV_WIDTH-1:0] quotient;
    logic [DIV_TAG_W-1:0] tag;
    logic                 div0;
  } div_result_t;

  function automatic int div_latency(input int width, input int q_bits);
    return width + q_bits;
  endfunction
endpackage

// File: rtl/div_result_fifo.sv
// Single-clock result FIFO with registered full/empty and a combinational head.
module div_result_fifo #(
  parameter int DATA_W = 23,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic [AW:0]       count_next;
  logic              full;
  logic              do_wr;
  logic              do_rd;

  // A write into a full FIFO is fine when the head leaves in the same cycle
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  always_comb begin
    count_next = count;
    case ({do_wr, do_rd})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      full  <= (count_next == (AW+1)'(DEPTH));
      empty <= (count_next == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];
endmodule

// File: rtl/fixed_div_stream_adapter.sv
// Credit-based stream wrapper around a fixed-latency, non-stalling divider.
`ifndef WIDTH
`define WIDTH 16
`endif
`ifndef Q_BITS
`define Q_BITS 12
`endif

module fixed_div_stream_adapter
  import div_pkg::*;
#(
  parameter int WIDTH     = `WIDTH,
  parameter int Q_BITS    = `Q_BITS,
  parameter int TAG_W     = 6,
  parameter int OUT_DEPTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_dividend,
  input  logic [WIDTH-1:0] in_divisor,
  input  logic [TAG_W-1:0] in_tag,
  output logic             div_start,
  output logic [WIDTH-1:0] div_dividend,
  output logic [WIDTH-1:0] div_divisor,
  input  logic [WIDTH-1:0] div_quotient,
  input  logic             div_valid,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_quotient,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_div0,
  output logic             seq_err
);
  localparam int DIV_LAT = div_latency(WIDTH, Q_BITS);
  localparam int CW      = $clog2(OUT_DEPTH) + 1;
  localparam int DATA_W  = WIDTH + TAG_W + 1;

  logic [CW-1:0]      credit;
  logic               run;
  logic               accept;
  logic               pop;
  logic [DIV_LAT-1:0] pipe_valid;
  logic [DIV_LAT-1:0] pipe_div0;
  logic [TAG_W-1:0]   pipe_tag [DIV_LAT];
  logic               head_valid;
  logic [DATA_W-1:0]  wr_data;
  logic [DATA_W-1:0]  rd_data;
  logic               fifo_empty;

  // run keeps in_ready low through reset and for the release edge itself
  assign in_ready = run && (credit != '0);
  assign accept   = in_valid && in_ready;
  assign pop      = out_valid && out_ready;

  assign div_start    = accept;
  assign div_dividend = accept ? in_dividend : '0;
  assign div_divisor  = accept ? in_divisor  : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      credit  <= CW'(OUT_DEPTH);
      run     <= 1'b0;
      seq_err <= 1'b0;
    end else begin
      run <= 1'b1;
      if (accept && !pop)
        credit <= credit - 1'b1;
      else if (!accept && pop)
        credit <= credit + 1'b1;
      if (head_valid != div_valid)
        seq_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      pipe_valid <= '0;
    else
      pipe_valid <= {pipe_valid[DIV_LAT-2:0], accept};
  end

  always_ff @(posedge clk) begin
    pipe_div0   <= {pipe_div0[DIV_LAT-2:0], accept && (in_divisor == '0)};
    pipe_tag[0] <= accept ? in_tag : '0;
    for (int i = 1; i < DIV_LAT; i++)
      pipe_tag[i] <= pipe_tag[i-1];
  end

  // A result with no matching issue record is still stored, but anonymously
  assign head_valid = pipe_valid[DIV_LAT-1];
  assign wr_data    = head_valid ? {div_quotient, pipe_tag[DIV_LAT-1], pipe_div0[DIV_LAT-1]}
                                 : {div_quotient, {TAG_W{1'b0}}, 1'b0};

  div_result_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (OUT_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (div_valid),
    .wr_data (wr_data),
    .rd_en   (pop),
    .rd_data (rd_data),
    .empty   (fifo_empty)
  );

  assign out_valid    = !fifo_empty;
  assign out_quotient = rd_data[DATA_W-1 -: WIDTH];
  assign out_tag      = rd_data[TAG_W:1];
  assign out_div0     = rd_data[0];
endmodule
